regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port integer register file for the RISC-V core. Successor to the fixed 2-read/1-write, 32x32 file.
- Adds configurable width, depth and read/write port counts, same-cycle write-to-read bypass, full reset clearing, and an integrated per-register pending scoreboard.
- Sits between decode (read/issue) and writeback. The stall signal is consumed by the hazard unit.

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers (power of two, >=2); AW = clog2(NREGS).
- NRD, 2, number of read ports (1..4).
- NWR, 1, number of write ports (1..2); a higher-index port wins on an address collision.
- BYPASS, 1, 1 = a read returns write data from the same cycle; 0 = a read returns the stored value.
- ZERO_REG, 1, 1 = register 0 is hardwired to zero and ignores writes and issues.

Ports:
- clk  input  1  clock, rising edge.
- resetn  input  1  asynchronous, active-low reset.
- rd_addr  input  NRD*AW  packed read addresses; port i uses bits [i*AW +: AW].
- rd_data  output  NRD*XLEN  packed read data, combinational.
- rd_pending  output  NRD  pending bit of each read address, combinational.
- wr_en  input  NWR  per-port write enable, active-high.
- wr_addr  input  NWR*AW  packed write addresses.
- wr_data  input  NWR*XLEN  packed write data.
- issue_valid  input  1  an instruction with a destination is issued this cycle.
- issue_rd  input  AW  destination of the issuing instruction.
- flush  input  1  synchronous clear of all pending bits (pipeline flush).
- stall  output  1  OR of rd_pending over ports with rd_en_mask set.
- rd_en_mask  input  NRD  marks which read ports the decoding instruction actually uses.

Behaviour:
- Reset (resetn=0, asynchronous): all NREGS entries = 0, all pending bits = 0. Outputs follow combinationally: rd_data = 0, rd_pending = 0, stall = 0.
- Write: on posedge clk, if wr_en[j] is set and the address is not (ZERO_REG and addr==0), then reg[wr_addr[j]] <= wr_data[j].
  - With NWR=2 and equal addresses, port 1's data is stored.
- Read: combinational.
  - If ZERO_REG and addr==0, rd_data = 0.
  - Else if BYPASS and some wr_en[j] matches rd_addr, rd_data = that wr_data (highest j wins).
  - Else rd_data = reg[addr].
- Scoreboard: one pending bit per register. At each posedge, in priority order:
  1. flush=1 → all bits cleared; a simultaneous issue is also discarded.
  2. Otherwise, a write on any port clears pending[wr_addr].
  3. issue_valid sets pending[issue_rd]. A set overrides a clear to the same address in the same cycle, because the new producer is outstanding.
  - With ZERO_REG=1, pending[0] is never set.
- rd_pending[i] = pending[rd_addr[i]] AND NOT (BYPASS and a same-cycle write to that address). The bypassed value is valid, so the register reads as not pending.
- stall = |(rd_pending & rd_en_mask). Combinational, zero latency. Writes do not depend on stall.
- Latency:
  - Write-to-read: 0 cycles with BYPASS=1, 1 cycle with BYPASS=0.
  - Issue-to-pending visible: 1 cycle.
- Reset mid-operation: all state is cleared immediately. In-flight writes are lost. The first posedge after resetn rises behaves normally.
- Addresses are AW bits wide, so NREGS being a power of two makes every address in range. No wrap-around or undefined index is possible.

Decomposition:
- Package rf_pkg holds the constants XLEN_DEF=32, NREGS_DEF=32, and the helper function clog2.
- Sub-module reg_scoreboard (pending bits, flush/clear/set priority) is instantiated once. The storage array, bypass muxes and stall logic stay in regfile_mp.
- A generate loop produces the read ports.

Test Plan:
1. Reset then read: assert resetn=0 mid-simulation, release, read addr 5 and 31 → 0x00000000. rd_pending=0, stall=0.
2. Write then read: write 0xDEADBEEF to x3, read x3 on both ports the same cycle → 0xDEADBEEF (BYPASS=1). Next cycle → 0xDEADBEEF. Write 0x1234 to x0 → x0 still reads 0.
3. Dual-write collision (NWR=2): both ports write x7, port0 0xAAAA and port1 0x5555 → x7 = 0x5555, and the same-cycle bypass also returns 0x5555.
4. Scoreboard hazard:
   - Issue rd=x9. Next cycle, read x9 with rd_en_mask=01 → rd_pending[0]=1, stall=1.
   - Write x9=0x42 → same cycle rd_pending=0, stall=0, rd_data=0x42.
   - Same sequence with rd_en_mask=00 → stall=0.
5. Simultaneous issue and writeback to x4 in one cycle → pending[4]=1 afterwards. Issue x6 with flush=1 → pending[6]=0, and all other bits are 0.
6. BYPASS=0 build: write 0x77 to x2 and read x2 the same cycle → old value 0. Next cycle → 0x77. A pending x2 shows rd_pending=1 during the write cycle.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared constants and helpers for the multi-port integer register file.
package rf_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned NREGS_DEF = 32;

  // Ceiling log2, usable in parameter expressions.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending bits: flush beats set, set beats a same-cycle writeback clear.
module reg_scoreboard
  import rf_pkg::*;
#(
  parameter int unsigned NREGS    = NREGS_DEF,
  parameter int unsigned NWR      = 1,
  parameter int unsigned ZERO_REG = 1,
  localparam int unsigned AW      = clog2(NREGS)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NWR-1:0]    wr_en_i,
  input  logic [NWR*AW-1:0] wr_addr_i,
  input  logic              issue_valid_i,
  input  logic [AW-1:0]     issue_rd_i,
  input  logic              flush_i,
  output logic [NREGS-1:0]  pending_o
);

  logic [NREGS-1:0] pending_d, pending_q;

  always_comb begin
    pending_d = pending_q;
    if (flush_i) begin
      pending_d = '0;
    end else begin
      for (int unsigned j = 0; j < NWR; j++) begin
        if (wr_en_i[j]) pending_d[wr_addr_i[j*AW +: AW]] = 1'b0;
      end
      // A new producer stays outstanding even if an older one retires this cycle.
      if (issue_valid_i) pending_d[issue_rd_i] = 1'b1;
    end
    if (ZERO_REG != 0) pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) pending_q <= '0;
    else         pending_q <= pending_d;
  end

  assign pending_o = pending_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with same-cycle bypass and an issue scoreboard.
module regfile_mp
  import rf_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEF,
  parameter int unsigned NREGS    = NREGS_DEF,
  parameter int unsigned NRD      = 2,
  parameter int unsigned NWR      = 1,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned ZERO_REG = 1,
  localparam int unsigned AW      = clog2(NREGS)
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [NRD*AW-1:0]   rd_addr_i,
  output logic [NRD*XLEN-1:0] rd_data_o,
  output logic [NRD-1:0]      rd_pending_o,
  input  logic [NWR-1:0]      wr_en_i,
  input  logic [NWR*AW-1:0]   wr_addr_i,
  input  logic [NWR*XLEN-1:0] wr_data_i,
  input  logic                issue_valid_i,
  input  logic [AW-1:0]       issue_rd_i,
  input  logic                flush_i,
  output logic                stall_o,
  input  logic [NRD-1:0]      rd_en_mask_i
);

  logic [XLEN-1:0]  regs_d [NREGS];
  logic [XLEN-1:0]  regs_q [NREGS];
  logic [NREGS-1:0] pending;

  // Later ports overwrite earlier ones, so the highest port wins a collision.
  always_comb begin
    regs_d = regs_q;
    for (int unsigned j = 0; j < NWR; j++) begin
      if (wr_en_i[j] && !((ZERO_REG != 0) && (wr_addr_i[j*AW +: AW] == '0))) begin
        regs_d[wr_addr_i[j*AW +: AW]] = wr_data_i[j*XLEN +: XLEN];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned k = 0; k < NREGS; k++) regs_q[k] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  reg_scoreboard #(
    .NREGS    (NREGS),
    .NWR      (NWR),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk           (clk),
    .resetn        (resetn),
    .wr_en_i       (wr_en_i),
    .wr_addr_i     (wr_addr_i),
    .issue_valid_i (issue_valid_i),
    .issue_rd_i    (issue_rd_i),
    .flush_i       (flush_i),
    .pending_o     (pending)
  );

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   addr;
    logic            hit;
    logic [XLEN-1:0] byp_data;
    logic [XLEN-1:0] data;

    assign addr = rd_addr_i[i*AW +: AW];

    always_comb begin
      hit      = 1'b0;
      byp_data = '0;
      if (BYPASS != 0) begin
        for (int unsigned j = 0; j < NWR; j++) begin
          if (wr_en_i[j] && (wr_addr_i[j*AW +: AW] == addr)) begin
            hit      = 1'b1;
            byp_data = wr_data_i[j*XLEN +: XLEN];
          end
        end
      end
    end

    always_comb begin
      if ((ZERO_REG != 0) && (addr == '0)) data = '0;
      else if (hit)                        data = byp_data;
      else                                 data = regs_q[addr];
    end

    assign rd_data_o[i*XLEN +: XLEN] = data;
    // A bypassed value is already valid, so it no longer counts as pending.
    assign rd_pending_o[i] = pending[addr] & ~hit;
  end

  assign stall_o = |(rd_pending_o & rd_en_mask_i);

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: dual-write bypassing build (A) and single-write non-bypass build (B).
module tb_regfile_mp;

  localparam int AW   = 5;
  localparam int XLEN = 32;
  localparam int NR   = 32;

  logic            clk = 1'b0;
  logic            resetn = 1'b1;
  logic [2*AW-1:0] rd_addr;
  logic [1:0]      rd_en_mask;
  logic [1:0]      wr_en;
  logic [2*AW-1:0] wr_addr;
  logic [63:0]     wr_data;
  logic            issue_valid;
  logic [AW-1:0]   issue_rd;
  logic            flush;

  logic [63:0] a_rd_data, b_rd_data;
  logic [1:0]  a_rd_pending, b_rd_pending;
  logic        a_stall, b_stall;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_mp #(
    .XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(1), .ZERO_REG(1)
  ) u_dut_a (
    .clk           (clk),
    .resetn        (resetn),
    .rd_addr_i     (rd_addr),
    .rd_data_o     (a_rd_data),
    .rd_pending_o  (a_rd_pending),
    .wr_en_i       (wr_en),
    .wr_addr_i     (wr_addr),
    .wr_data_i     (wr_data),
    .issue_valid_i (issue_valid),
    .issue_rd_i    (issue_rd),
    .flush_i       (flush),
    .stall_o       (a_stall),
    .rd_en_mask_i  (rd_en_mask)
  );

  regfile_mp #(
    .XLEN(32), .NREGS(32), .NRD(2), .NWR(1), .BYPASS(0), .ZERO_REG(1)
  ) u_dut_b (
    .clk           (clk),
    .resetn        (resetn),
    .rd_addr_i     (rd_addr),
    .rd_data_o     (b_rd_data),
    .rd_pending_o  (b_rd_pending),
    .wr_en_i       (wr_en[0]),
    .wr_addr_i     (wr_addr[AW-1:0]),
    .wr_data_i     (wr_data[31:0]),
    .issue_valid_i (issue_valid),
    .issue_rd_i    (issue_rd),
    .flush_i       (flush),
    .stall_o       (b_stall),
    .rd_en_mask_i  (rd_en_mask)
  );

  // Architectural model: index 0 = build A (2 write ports, bypass), 1 = build B.
  logic [31:0] m_regs [2][NR];
  bit          m_pend [2][NR];

  function automatic int nwr_of(int d);
    return (d == 0) ? 2 : 1;
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int d = 0; d < 2; d++)
        for (int r = 0; r < NR; r++) begin
          m_regs[d][r] <= 32'd0;
          m_pend[d][r] <= 1'b0;
        end
    end else begin
      for (int d = 0; d < 2; d++) begin
        for (int j = 0; j < nwr_of(d); j++)
          if (wr_en[j] && wr_addr[j*AW +: AW] != 0) m_regs[d][wr_addr[j*AW +: AW]] <= wr_data[j*32 +: 32];
        if (flush) begin
          for (int r = 0; r < NR; r++) m_pend[d][r] <= 1'b0;
        end else begin
          for (int j = 0; j < nwr_of(d); j++)
            if (wr_en[j]) m_pend[d][wr_addr[j*AW +: AW]] <= 1'b0;
          if (issue_valid && issue_rd != 0) m_pend[d][issue_rd] <= 1'b1;
        end
      end
    end
  end

  function automatic bit bypass_hit(int d, logic [AW-1:0] a);
    if (d != 0) return 1'b0;
    for (int j = 0; j < 2; j++)
      if (wr_en[j] && wr_addr[j*AW +: AW] == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] exp_data(int d, logic [AW-1:0] a);
    logic [31:0] v;
    if (a == 0) return 32'd0;
    v = m_regs[d][a];
    if (d == 0)
      for (int j = 0; j < 2; j++)
        if (wr_en[j] && wr_addr[j*AW +: AW] == a) v = wr_data[j*32 +: 32];
    return v;
  endfunction

  function automatic bit exp_pend(int d, logic [AW-1:0] a);
    return m_pend[d][a] && !bypass_hit(d, a);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Continuous comparison against the model on every falling edge.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic [63:0] dat;
      logic [1:0]  pnd;
      logic        stl, exp_stl;
      dat = (d == 0) ? a_rd_data : b_rd_data;
      pnd = (d == 0) ? a_rd_pending : b_rd_pending;
      stl = (d == 0) ? a_stall : b_stall;
      exp_stl = 1'b0;
      for (int i = 0; i < 2; i++) begin
        logic [AW-1:0] a;
        a = rd_addr[i*AW +: AW];
        chk($sformatf("model dut%0d rd_data[%0d]", d, i), dat[i*32 +: 32], exp_data(d, a));
        chk($sformatf("model dut%0d rd_pending[%0d]", d, i), {31'd0, pnd[i]}, {31'd0, exp_pend(d, a)});
        if (exp_pend(d, a) && rd_en_mask[i]) exp_stl = 1'b1;
      end
      chk($sformatf("model dut%0d stall", d), {31'd0, stl}, {31'd0, exp_stl});
    end
  end

  task automatic idle();
    wr_en = 2'b00; issue_valid = 1'b0; flush = 1'b0; rd_en_mask = 2'b00;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic next();
    @(posedge clk); #1;
  endtask

  task automatic wr0(input logic [AW-1:0] a, input logic [31:0] v);
    wr_en[0] = 1'b1; wr_addr[AW-1:0] = a; wr_data[31:0] = v;
  endtask

  task automatic rd(input logic [AW-1:0] a1, input logic [AW-1:0] a0);
    rd_addr = {a1, a0};
  endtask

  initial begin
    idle(); rd_addr = '0; wr_addr = '0; wr_data = '0; issue_rd = '0;
    #1 resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    settle();
    chk("init x0", a_rd_data[31:0], 32'd0);

    // 1. populate, then reset mid-cycle
    next(); wr0(5'd5, 32'h0000CAFE);
    next(); idle(); wr0(5'd31, 32'h00000031); issue_valid = 1'b1; issue_rd = 5'd5;
    next(); idle(); rd(5'd31, 5'd5); rd_en_mask = 2'b11;
    settle();
    chk("pre-reset x5", a_rd_data[31:0], 32'h0000CAFE);
    chk("pre-reset x31", b_rd_data[63:32], 32'h00000031);
    chk("pre-reset stall", {31'd0, a_stall}, 32'd1);
    #2 resetn = 1'b0; #1;
    chk("in-reset x5", a_rd_data[31:0], 32'd0);
    chk("in-reset x31", a_rd_data[63:32], 32'd0);
    chk("in-reset stall", {31'd0, a_stall}, 32'd0);
    next(); resetn = 1'b1;
    settle();
    chk("post-reset x31 b", b_rd_data[63:32], 32'd0);
    chk("post-reset pend", {30'd0, a_rd_pending}, 32'd0);

    // 2. write/read, bypass, x0
    next(); idle(); wr0(5'd3, 32'hDEADBEEF); rd(5'd3, 5'd3);
    settle();
    chk("bypass x3 p0", a_rd_data[31:0], 32'hDEADBEEF);
    chk("bypass x3 p1", a_rd_data[63:32], 32'hDEADBEEF);
    chk("nobypass x3", b_rd_data[31:0], 32'd0);
    next(); idle();
    settle();
    chk("stored x3 a", a_rd_data[31:0], 32'hDEADBEEF);
    chk("stored x3 b", b_rd_data[31:0], 32'hDEADBEEF);
    next(); wr0(5'd0, 32'h00001234); rd(5'd0, 5'd0);
    settle();
    chk("x0 bypass", a_rd_data[31:0], 32'd0);
    next(); idle();
    settle();
    chk("x0 stored", b_rd_data[31:0], 32'd0);

    // 3. dual-write collision
    next(); wr_en = 2'b11; wr_addr = {5'd7, 5'd7}; wr_data = {32'h00005555, 32'h0000AAAA};
    rd(5'd7, 5'd7);
    settle();
    chk("collide bypass", a_rd_data[63:32], 32'h00005555);
    next(); idle();
    settle();
    chk("collide stored", a_rd_data[31:0], 32'h00005555);
    chk("single port b", b_rd_data[31:0], 32'h0000AAAA);

    // 4. scoreboard hazard
    next(); issue_valid = 1'b1; issue_rd = 5'd9; rd(5'd9, 5'd9); rd_en_mask = 2'b01;
    settle();
    chk("issue not yet", {31'd0, a_rd_pending[0]}, 32'd0);
    next(); issue_valid = 1'b0;
    settle();
    chk("x9 pending", {31'd0, a_rd_pending[0]}, 32'd1);
    chk("x9 stall", {31'd0, a_stall}, 32'd1);
    next(); wr0(5'd9, 32'h00000042);
    settle();
    chk("wb pend a", {31'd0, a_rd_pending[0]}, 32'd0);
    chk("wb stall a", {31'd0, a_stall}, 32'd0);
    chk("wb data a", a_rd_data[31:0], 32'h00000042);
    chk("wb pend b", {31'd0, b_rd_pending[0]}, 32'd1);
    chk("wb stall b", {31'd0, b_stall}, 32'd1);
    next(); idle(); issue_valid = 1'b1; issue_rd = 5'd9;
    next(); idle(); rd_en_mask = 2'b00;
    settle();
    chk("mask0 pend", {31'd0, a_rd_pending[0]}, 32'd1);
    chk("mask0 stall", {31'd0, a_stall}, 32'd0);

    // 5. issue+writeback collision, then flush
    next(); wr0(5'd4, 32'h00000004); issue_valid = 1'b1; issue_rd = 5'd4;
    next(); idle(); rd(5'd4, 5'd4);
    settle();
    chk("issue beats clear a", {31'd0, a_rd_pending[0]}, 32'd1);
    chk("issue beats clear b", {31'd0, b_rd_pending[1]}, 32'd1);
    next(); issue_valid = 1'b1; issue_rd = 5'd6; flush = 1'b1;
    next(); idle(); rd(5'd4, 5'd6);
    settle();
    chk("flush drops x6", {31'd0, a_rd_pending[0]}, 32'd0);
    chk("flush clears x4", {31'd0, a_rd_pending[1]}, 32'd0);
    next(); issue_valid = 1'b1; issue_rd = 5'd0;
    next(); idle(); rd(5'd9, 5'd0);
    settle();
    chk("x0 never pending", {31'd0, b_rd_pending[0]}, 32'd0);
    chk("x9 flushed", {31'd0, a_rd_pending[1]}, 32'd0);

    // 6. non-bypass build latency and pending during write
    next(); issue_valid = 1'b1; issue_rd = 5'd2;
    next(); idle(); wr0(5'd2, 32'h00000077); rd(5'd2, 5'd2); rd_en_mask = 2'b01;
    settle();
    chk("nb old value", b_rd_data[31:0], 32'd0);
    chk("nb pend in wr", {31'd0, b_rd_pending[0]}, 32'd1);
    chk("nb stall in wr", {31'd0, b_stall}, 32'd1);
    chk("by value in wr", a_rd_data[31:0], 32'h00000077);
    next(); idle();
    settle();
    chk("nb new value", b_rd_data[31:0], 32'h00000077);
    chk("nb pend cleared", {31'd0, b_rd_pending[0]}, 32'd0);

    next();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
